// File: rtl/imem_loader_if.sv
// ============================================================================
// Module      : imem_loader_if
// Description : Byte-stream handshake plus instruction-memory write bus used
//               by the boot loader. "master" is the host/stream side, "slave"
//               is the loader.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface imem_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic                  byte_valid;
  logic [7:0]            byte_data;
  logic                  byte_ready;
  logic                  imem_wren;
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic [31:0]           imem_data;

  modport master (
    output byte_valid, byte_data,
    input  byte_ready, imem_wren, imem_addr, imem_data
  );

  modport slave (
    input  byte_valid, byte_data,
    output byte_ready, imem_wren, imem_addr, imem_data
  );
endinterface

`default_nettype wire

// File: rtl/imem_loader.sv
// ============================================================================
// Module      : imem_loader
// Description : Serial boot loader. Receives a 16-bit big-endian word count
//               followed by big-endian 32-bit words over a byte handshake,
//               writes them to sequential instruction-memory addresses and
//               holds the CPU in reset until the image is complete.
//               Optional trailing XOR checksum byte: IMEM_LOADER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_loader #(
  parameter int ADDR_WIDTH = 12,
  parameter int MAX_WORDS  = 4096
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         start,
  imem_loader_if.slave bus,
  output logic         cpu_reset,
  output logic         busy,
  output logic         done,
  output logic         error
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LEN_HI = 3'd1,
    S_LEN_LO = 3'd2,
    S_DATA   = 3'd3,
    S_LAST   = 3'd4,  // final write strobe in flight, no byte accepted
    S_CHK    = 3'd5,
    S_DONE   = 3'd6,
    S_ERR    = 3'd7
  } state_t;

  localparam logic [ADDR_WIDTH:0] IDX_ONE = 1;

  state_t                state;
  state_t                next;
  logic                  ready;
  logic                  accept;
  logic                  restart;
  logic [7:0]            len_hi;
  logic [15:0]           len_words;
  logic [15:0]           len_in;
  logic                  len_bad;
  logic [ADDR_WIDTH:0]   idx;
  logic [1:0]            byte_cnt;
  logic                  last_word;
  logic                  wr_strobe;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [31:0]           wr_word;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0]            chk;
`endif

  assign ready   = (state == S_LEN_HI) || (state == S_LEN_LO) ||
                   (state == S_DATA)   || (state == S_CHK);
  assign accept  = bus.byte_valid && ready;
  assign restart = start && ((state == S_IDLE) || (state == S_DONE) || (state == S_ERR));

  assign len_in    = {len_hi, bus.byte_data};
  assign len_bad   = (len_in == 16'd0) || (32'(len_in) > 32'(MAX_WORDS));
  // idx is one bit wider than the address so a full 2^ADDR_WIDTH image never wraps
  assign last_word = ((32'(idx) + 1) == 32'(len_words));

  assign bus.byte_ready = ready;
  assign bus.imem_wren  = wr_strobe;
  assign bus.imem_addr  = wr_addr;
  assign bus.imem_data  = wr_word;

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= S_IDLE;
    else        state <= next;
  end

  // Next-state and status decode
  always_comb begin
    next      = state;
    busy      = 1'b0;
    done      = 1'b0;
    error     = 1'b0;
    cpu_reset = 1'b1;
    case (state)
      S_IDLE: begin
        if (start) next = S_LEN_HI;
      end
      S_LEN_HI: begin
        busy = 1'b1;
        if (accept) next = S_LEN_LO;
      end
      S_LEN_LO: begin
        busy = 1'b1;
        if (accept) next = len_bad ? S_ERR : S_DATA;
      end
      S_DATA: begin
        busy = 1'b1;
        if (accept && (byte_cnt == 2'd3) && last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          next = S_CHK;
`else
          next = S_LAST;
`endif
        end
      end
      S_LAST: begin
        busy = 1'b1;
        next = S_DONE;
      end
      S_CHK: begin
        busy = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
        if (accept) next = (bus.byte_data == chk) ? S_DONE : S_ERR;
`else
        next = S_IDLE;
`endif
      end
      S_DONE: begin
        done      = 1'b1;
        cpu_reset = 1'b0;
        if (start) next = S_LEN_HI;
      end
      S_ERR: begin
        error = 1'b1;
        if (start) next = S_LEN_HI;
      end
      default: next = S_IDLE;
    endcase
  end

  // Length capture, word assembly and registered write strobe
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      len_hi    <= 8'd0;
      len_words <= 16'd0;
      idx       <= '0;
      byte_cnt  <= 2'd0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
      wr_word   <= 32'd0;
    end else begin
      wr_strobe <= 1'b0;
      if (restart) begin
        idx      <= '0;
        byte_cnt <= 2'd0;
      end
      if ((state == S_LEN_HI) && accept) len_hi <= bus.byte_data;
      if ((state == S_LEN_LO) && accept) len_words <= len_in;
      if ((state == S_DATA) && accept) begin
        wr_word  <= {wr_word[23:0], bus.byte_data};
        byte_cnt <= byte_cnt + 2'd1;
        if (byte_cnt == 2'd3) begin
          wr_strobe <= 1'b1;
          wr_addr   <= idx[ADDR_WIDTH-1:0];
          idx       <= idx + IDX_ONE;
        end
      end
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  // Running XOR over every payload byte of the current load
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      chk <= 8'd0;
    end else if (restart) begin
      chk <= 8'd0;
    end else if ((state == S_DATA) && accept) begin
      chk <= chk ^ bus.byte_data;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_imem_loader.sv
// ============================================================================
// Module      : tb_imem_loader
// Description : Self-checking bench for imem_loader with a stream-level
//               reference model of the expected memory image and end state.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_imem_loader;
  localparam int AW   = 12;
  localparam int MAXW = 4096;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic start = 1'b0;
  logic cpu_reset, busy, done, error;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW), .MAX_WORDS(MAXW)) dut (
    .clock(clock), .reset(reset), .start(start), .bus(bus),
    .cpu_reset(cpu_reset), .busy(busy), .done(done), .error(error)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  int         n_checks = 0;
  int         n_fail   = 0;
  wr_t        got_q[$];
  wr_t        exp_q[$];
  bit         exp_done, exp_err;
  logic [7:0] stream[$];
  int         pulse_err = 0;
  logic       prev_wren = 1'b0;
  int         timeouts;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Capture every write strobe; flag strobes lasting more than one cycle
  always @(negedge clock) begin
    if (bus.imem_wren === 1'b1) begin
      got_q.push_back(wr_t'({bus.imem_addr, bus.imem_data}));
      if (prev_wren === 1'b1) pulse_err <= pulse_err + 1;
    end
    prev_wren <= bus.imem_wren;
  end

  // Reference: interpret the byte stream as a length header plus words
  task automatic model();
    int n;
    logic [7:0]  x;
    logic [31:0] w;
    exp_q.delete();
    exp_done = 1'b0;
    exp_err  = 1'b0;
    n = int'(stream[0]) * 256 + int'(stream[1]);
    if (n == 0 || n > MAXW) begin
      exp_err = 1'b1;
      return;
    end
    x = 8'h00;
    for (int k = 0; k < n; k++) begin
      w = 32'd0;
      for (int b = 0; b < 4; b++) begin
        w = (w << 8) | 32'(stream[2 + 4*k + b]);
        x = x ^ stream[2 + 4*k + b];
      end
      exp_q.push_back(wr_t'({k[AW-1:0], w}));
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_done = (stream[2 + 4*n] == x);
    exp_err  = !exp_done;
`else
    exp_done = 1'b1;
`endif
  endtask

  task automatic make_stream(input int n, input bit bad_chk);
    logic [7:0] x = 8'h00;
    logic [7:0] b;
    stream.delete();
    stream.push_back(8'(n >> 8));
    stream.push_back(8'(n));
    for (int k = 0; k < 4*n; k++) begin
      b = 8'($urandom);
      x = x ^ b;
      stream.push_back(b);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(bad_chk ? (x ^ 8'h01) : x);
`else
    if (bad_chk) stream.push_back(x);
`endif
  endtask

  // Offer the first 'count' stream bytes; returns on the negedge after the last accept
  task automatic send_bytes(input bit rnd, input int count);
    timeouts = 0;
    for (int i = 0; i < count; i++) begin
      bit acc = 1'b0;
      int guard = 0;
      while (!acc && guard < 64) begin
        @(negedge clock);
        bus.byte_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
        bus.byte_data  = stream[i];
        acc = bus.byte_valid && bus.byte_ready;
        guard++;
      end
      if (!acc) timeouts++;
    end
    @(negedge clock);
    bus.byte_valid = 1'b0;
  endtask

  task automatic do_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"},     bus.byte_ready, 1'b0);
    check({tag, "_wren"},      bus.imem_wren,  1'b0);
    check({tag, "_addr"},      bus.imem_addr,  '0);
    check({tag, "_data"},      bus.imem_data,  32'd0);
    check({tag, "_cpu_reset"}, cpu_reset,      1'b1);
    check({tag, "_busy"},      busy,           1'b0);
    check({tag, "_done"},      done,           1'b0);
    check({tag, "_error"},     error,          1'b0);
  endtask

  task automatic compare_writes(input string tag);
    int bad = 0;
    int first = -1;
    check({tag, "_write_count"}, got_q.size(), exp_q.size());
    for (int k = 0; k < got_q.size() && k < exp_q.size(); k++) begin
      if (got_q[k] !== exp_q[k]) begin
        bad++;
        if (first < 0) first = k;
      end
    end
    check({tag, "_write_mismatches"}, bad, 0);
    if (first >= 0)
      $display("  %s first bad write %0d: got %h want %h", tag, first, got_q[first], exp_q[first]);
    check({tag, "_wren_single_cycle"}, pulse_err, 0);
  endtask

  // Full load of the current stream, followed by end-state checks
  task automatic run_load(input string tag, input bit rnd);
    model();
    got_q.delete();
    pulse_err = 0;
    do_start();
    check({tag, "_ready_after_start"}, bus.byte_ready, 1'b1);
    check({tag, "_busy_after_start"},  busy,           1'b1);
    send_bytes(rnd, stream.size());
    check({tag, "_timeouts"}, timeouts, 0);
`ifndef IMEM_LOADER_CHECKSUM_EN
    check({tag, "_last_wren"},           bus.imem_wren, 1'b1);
    check({tag, "_cpu_reset_last_wr"},   cpu_reset,     1'b1);
    check({tag, "_done_before_commit"},  done,          1'b0);
`endif
    @(negedge clock);
    @(negedge clock);
    check({tag, "_done"},      done,      exp_done);
    check({tag, "_error"},     error,     exp_err);
    check({tag, "_cpu_reset"}, cpu_reset, !exp_done);
    check({tag, "_busy"},      busy,      1'b0);
    compare_writes(tag);
  endtask

  task automatic run_len_err(input string tag, input logic [7:0] hi, input logic [7:0] lo);
    stream.delete();
    stream.push_back(hi);
    stream.push_back(lo);
    model();
    got_q.delete();
    do_start();
    send_bytes(1'b0, 2);
    check({tag, "_error"},     error,          1'b1);
    check({tag, "_busy"},      busy,           1'b0);
    check({tag, "_ready"},     bus.byte_ready, 1'b0);
    check({tag, "_cpu_reset"}, cpu_reset,      1'b1);
    repeat (3) @(negedge clock);
    check({tag, "_writes"},    got_q.size(),   0);
    check({tag, "_model_err"}, error,          exp_err);
    do_start();
    check({tag, "_recover_busy"},  busy,  1'b1);
    check({tag, "_recover_error"}, error, 1'b0);
  endtask

  task automatic set_spec_stream();
    stream = '{8'h00, 8'h02, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h01, 8'h23, 8'h45, 8'h67};
`ifdef IMEM_LOADER_CHECKSUM_EN
    stream.push_back(8'hDE ^ 8'hAD ^ 8'hBE ^ 8'hEF ^ 8'h01 ^ 8'h23 ^ 8'h45 ^ 8'h67);
`endif
  endtask

  initial begin
    bus.byte_valid = 1'b0;
    bus.byte_data  = 8'h00;

    // Reset state, both during and after reset
    repeat (3) @(negedge clock);
    check_reset_values("in_reset");
    reset = 1'b1;
    @(negedge clock);
    check_reset_values("after_reset");

    // Start with no bytes: waiting for length, no writes
    got_q.delete();
    do_start();
    check("nobytes_busy",      busy,           1'b1);
    check("nobytes_ready",     bus.byte_ready, 1'b1);
    check("nobytes_cpu_reset", cpu_reset,      1'b1);
    repeat (5) @(negedge clock);
    check("nobytes_writes",    got_q.size(),   0);
    check("nobytes_still_busy", busy,          1'b1);
    #1 reset = 1'b0;
    @(negedge clock);
    reset = 1'b1;

    // Directed two-word image, back-to-back then with gaps
    set_spec_stream();
    run_load("spec_b2b", 1'b0);
    check("spec_word0", got_q.size() > 0 ? got_q[0] : '0, wr_t'({12'd0, 32'hDEADBEEF}));
    check("spec_word1", got_q.size() > 1 ? got_q[1] : '0, wr_t'({12'd1, 32'h01234567}));
    run_load("spec_gaps", 1'b1);

    // Length errors and recovery
    run_len_err("len_zero", 8'h00, 8'h00);
    run_len_err("len_4097", 8'h10, 8'h01);
    make_stream(3, 1'b0);
    run_load("after_err", 1'b1);

    // Randomized images
    for (int it = 0; it < 4; it++) begin
      make_stream($urandom_range(1, 6), 1'b0);
      run_load("rand", 1'b1);
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h44};
    run_load("chk_good", 1'b0);
    check("chk_good_done", done, 1'b1);
    stream = '{8'h00, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44, 8'h45};
    run_load("chk_bad", 1'b0);
    check("chk_bad_error", error, 1'b1);
    check("chk_bad_write0", got_q.size() > 0 ? got_q[0] : '0, wr_t'({12'd0, 32'h11223344}));
    make_stream(4, 1'b1);
    run_load("chk_rand_bad", 1'b1);
`endif

    // Largest image: index reaches MAX_WORDS without wrapping
    make_stream(MAXW, 1'b0);
    run_load("max_words", 1'b0);
    check("max_last_addr", got_q.size() > 0 ? 32'(got_q[got_q.size()-1].addr) : 32'hFFFF_FFFF, MAXW - 1);

    // Reset during payload, then a clean reload from address 0
    set_spec_stream();
    do_start();
    send_bytes(1'b0, 7);
    #1 reset = 1'b0;
    #1 check_reset_values("midload_reset");
    @(negedge clock);
    reset = 1'b1;
    run_load("post_reset", 1'b1);
    check("post_reset_word0", got_q.size() > 0 ? got_q[0] : '0, wr_t'({12'd0, 32'hDEADBEEF}));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Absolute time bound so the run always terminates
  initial begin
    #2_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
